// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
// A destination tag follows each instruction through the EX, MEM and WB slots.
package mips_pipe_pkg;

    localparam int TAG_ADDR_W = 5;

    // EX operand select encoding
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    localparam logic [TAG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [TAG_ADDR_W-1:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_read;
        logic [TAG_ADDR_W-1:0] dest;
        logic [TAG_ADDR_W-1:0] rs;
        logic [TAG_ADDR_W-1:0] rt;
    } pipe_tag_t;

    localparam pipe_tag_t TAG_NOP = '{valid: 1'b0, reg_write: 1'b0, mem_read: 1'b0,
                                      dest: 5'd0, rs: 5'd0, rt: 5'd0};

    // A slot produces register r only for a live write to a non-zero register
    function automatic logic tag_writes(input pipe_tag_t tag, input logic [TAG_ADDR_W-1:0] r);
        return tag.valid & tag.reg_write & (tag.dest == r) & (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle between the ID/EX datapath and the hazard controller.
// master: the datapath (drives decode info, consumes enables/selects).
// slave: the hazard controller.
interface pipeline_hazard_controller_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  id_reg_write;
    logic [REG_ADDR_W-1:0] id_dest;
    logic                  id_mem_read;
    logic                  id_jump;
    logic                  id_jr;
    logic                  ex_branch_taken;
    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_bubble;
    logic [1:0]            forward_a;
    logic [1:0]            forward_b;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write,
               id_dest, id_mem_read, id_jump, id_jr, ex_branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
               forward_a, forward_b, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write,
               id_dest, id_mem_read, id_jump, id_jr, ex_branch_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
               forward_a, forward_b, stall_count, flush_count
    );

endinterface

// File: rtl/hazard_forward_select.sv
// Picks the source of one EX operand: the MEM slot result beats the WB
// slot result, and register $0 is never forwarded.
module hazard_forward_select
    import mips_pipe_pkg::*;
(
    input  logic [TAG_ADDR_W-1:0] src_reg,
    input  logic                  mem_wr,
    input  logic [TAG_ADDR_W-1:0] mem_dest,
    input  logic                  wb_wr,
    input  logic [TAG_ADDR_W-1:0] wb_dest,
    output logic [1:0]            sel
);

    logic src_live_s;

    assign src_live_s = (src_reg != REG_ZERO);

    // Priority compare: youngest producer wins
    always_comb begin
        sel = FWD_REGFILE;
        if (src_live_s && mem_wr && (mem_dest == src_reg)) begin
            sel = FWD_EXMEM;
        end else if (src_live_s && wb_wr && (wb_dest == src_reg)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_REGFILE;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for the 5-stage MIPS pipeline: tracks destination tags
// for EX/MEM/WB, raises load-use and jr stalls, flushes IF_ID on taken
// branches and jumps, selects EX forwarding, and counts stall/flush cycles.
module pipeline_hazard_controller
    import mips_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    pipeline_hazard_controller_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pipe_tag_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic [REG_ADDR_W-1:0] id_rs_s, id_rt_s, id_dest_s;
    logic load_use_s, jr_stall_s, stall_s;
    logic pc_write_s, if_id_write_s, flush_s, bubble_s;
    logic unused_tag_bits_s;

    assign id_rs_s   = bus.id_rs;
    assign id_rt_s   = bus.id_rt;
    assign id_dest_s = bus.id_dest;

    // Source fields are only consumed while the instruction sits in EX
    assign unused_tag_bits_s = ^{mem_q.rs, mem_q.rt, wb_q.rs, wb_q.rt, wb_q.mem_read};

    // Hazard detection against the EX and MEM producers
    always_comb begin
        load_use_s = bus.id_valid & ex_q.mem_read &
                     ((bus.id_uses_rs & tag_writes(ex_q, id_rs_s)) |
                      (bus.id_uses_rt & tag_writes(ex_q, id_rt_s)));
        jr_stall_s = bus.id_jr & bus.id_valid &
                     (tag_writes(ex_q, id_rs_s) |
                      (mem_q.mem_read & tag_writes(mem_q, id_rs_s)));
        stall_s    = load_use_s | jr_stall_s;
    end

    // Pipeline control: taken branch > stall > jump/jr > idle
    always_comb begin
        pc_write_s    = 1'b1;
        if_id_write_s = 1'b1;
        flush_s       = 1'b0;
        bubble_s      = 1'b0;
        if (bus.ex_branch_taken) begin
            flush_s  = 1'b1;
            bubble_s = 1'b1;
        end else if (stall_s) begin
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            bubble_s      = 1'b1;
        end else if (bus.id_jump | bus.id_jr) begin
            flush_s = 1'b1;
        end else begin
            flush_s = 1'b0;
        end
    end

    // Next state of the tag shadow pipeline and the saturating counters
    always_comb begin
        mem_d = ex_q;
        wb_d  = mem_q;
        if (bubble_s) begin
            ex_d = TAG_NOP;
        end else begin
            ex_d.valid     = bus.id_valid;
            ex_d.reg_write = bus.id_reg_write;
            ex_d.mem_read  = bus.id_mem_read;
            ex_d.dest      = id_dest_s;
            ex_d.rs        = id_rs_s;
            ex_d.rt        = id_rt_s;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall_s && !bus.ex_branch_taken && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        flush_cnt_d = flush_cnt_q;
        if (flush_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= TAG_NOP;
            mem_q       <= TAG_NOP;
            wb_q        <= TAG_NOP;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    hazard_forward_select u_fwd_a (
        .src_reg  (ex_q.rs),
        .mem_wr   (mem_q.valid & mem_q.reg_write),
        .mem_dest (mem_q.dest),
        .wb_wr    (wb_q.valid & wb_q.reg_write),
        .wb_dest  (wb_q.dest),
        .sel      (bus.forward_a)
    );

    hazard_forward_select u_fwd_b (
        .src_reg  (ex_q.rt),
        .mem_wr   (mem_q.valid & mem_q.reg_write),
        .mem_dest (mem_q.dest),
        .wb_wr    (wb_q.valid & wb_q.reg_write),
        .wb_dest  (wb_q.dest),
        .sel      (bus.forward_b)
    );

    assign bus.pc_write     = pc_write_s;
    assign bus.if_id_write  = if_id_write_s;
    assign bus.if_id_flush  = flush_s;
    assign bus.id_ex_bubble = bubble_s;
    assign bus.stall_count  = stall_cnt_q;
    assign bus.flush_count  = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the pipelined MIPS datapath once the ID/EX, EX/MEM and MEM/WB registers sit behind the IF_ID stage.
- Keeps a shadow pipeline of destination-register tags for the EX, MEM and WB slots.
- From those tags it drives the PC/IF_ID write enables, IF_ID flush, ID/EX bubble insertion and EX-stage operand forwarding selects.
- Also counts stall and flush cycles for bring-up debug.

Parameters:
REG_ADDR_W, 5, register-file address width
CNT_W, 16, width of the stall and flush event counters (saturating)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
id_valid  input  1  ID stage holds a real instruction
id_rs  input  REG_ADDR_W  rs field of the ID instruction
id_rt  input  REG_ADDR_W  rt field of the ID instruction
id_uses_rs  input  1  ID instruction reads rs
id_uses_rt  input  1  ID instruction reads rt
id_reg_write  input  1  ID instruction writes the register file
id_dest  input  REG_ADDR_W  destination after RegDst/JAL muxing (31 for jal)
id_mem_read  input  1  ID instruction is lw
id_jump  input  1  j or jal decoded in ID
id_jr  input  1  jr decoded in ID (opcode 0, funct 8)
ex_branch_taken  input  1  beq/bne resolved taken in EX
pc_write  output  1  PC register load enable
if_id_write  output  1  IF_ID register load enable
if_id_flush  output  1  IF_ID loads a NOP on next edge
id_ex_bubble  output  1  ID/EX loads a NOP (control zeroed) on next edge
forward_a  output  2  EX operand A select: 00 regfile, 10 EX/MEM result, 01 MEM/WB writeback
forward_b  output  2  EX operand B select, same encoding
stall_count  output  CNT_W  cycles with load-use or jr stall asserted
flush_count  output  CNT_W  cycles with if_id_flush asserted

Behaviour:
- Shadow slots EX, MEM and WB each hold: valid, reg_write, dest, mem_read, rs, rt. The rs and rt fields are only needed in EX.
- On every clock edge: WB<=MEM, MEM<=EX, EX<=ID fields.
- When id_ex_bubble=1, the EX slot instead loads valid=0.
- A slot "writes r" iff valid & reg_write & dest==r & r!=0. Register $0 never creates a hazard and is never forwarded.
- Load-use stall: EX slot has mem_read and writes id_rs (with id_uses_rs) or id_rt (with id_uses_rt), and id_valid=1.
- jr stall: id_jr & id_valid, and either the EX slot writes id_rs (any instruction) or the MEM slot has mem_read and writes id_rs.
- stall = load-use | jr stall. While stall: pc_write=0, if_id_write=0, id_ex_bubble=1. Exactly one bubble per cycle of stall; stall re-evaluates each cycle.
- ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1. It overrides stall in the same cycle, so the stall does not count.
- id_jump or (id_jr without stall), with no ex_branch_taken: if_id_flush=1, no bubble, pc_write=1.
- Branch taken and jump in the same cycle: the branch wins. Its flush already squashes the ID jump.
- Idle (none of the above): pc_write=1, if_id_write=1, flush=0, bubble=0.
- forward_a: 10 if the MEM slot writes EX.rs. Else 01 if the WB slot writes EX.rs. Else 00. MEM has priority over WB. forward_b is the same using EX.rs→EX.rt.
- All control outputs are combinational from the registered slots plus current ID/EX inputs. There is zero added latency.
- Counters increment on the clock edge when their condition holds and saturate at all-ones.
- Reset (asynchronous, any time, including mid-stall):
  - all slots valid=0; counters=0
  - outputs settle to pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, forward_a=forward_b=00

Decomposition:
- Shared package mips_pipe_pkg:
  - FWD_REGFILE=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10
  - REG_ZERO=0, REG_RA=31
  - pipe_tag_t struct {valid, reg_write, mem_read, dest, rs, rt}
- One natural sub-module, hazard_forward_select: a combinational comparator producing one 2-bit select from (src, MEM tag, WB tag). Instantiate it twice, once for A and once for B.

Test Plan:
- lw $t0 in EX (dest 8), ID add uses rs=8 → one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count goes 0→1. Next cycle (EX slot now a bubble) stall=0 and forward_a=01 once the lw reaches WB.
- add $t1 (dest 9) in MEM, add in EX with rs=9, rt=9 → forward_a=10, forward_b=10. Same case with dest 9 also in WB → still 10.
- EX producer with dest=0 and EX reader of rs=0 → forward_a=00, no stall.
- ex_branch_taken=1 while a load-use condition also holds → if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_count+1, stall_count unchanged.
- jr $ra with jal (dest 31) in EX → stall for 1 cycle. Next cycle if_id_flush=1, pc_write=1.
- Assert reset mid-stall (asynchronously, between edges) → outputs return to idle values immediately and counters read 0.
